// File: rtl/bcd_div11_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_div11_seq_ctrl
//   Sequential BCD divisibility-by-11 checker. A packed BCD word is accepted
//   over a valid/ready handshake, then walked one digit per clock, most
//   significant digit first, while a running remainder mod 11 is kept. The
//   result (DIVISIBLE, REMAINDER, BCD_ERR) is offered over a second
//   valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising CLK edge
//   where VALID and READY are both 1. The producer holds VALID and its data
//   stable until that edge; READY never depends combinationally on VALID.
//
// Ports
//   CLK        in   1             system clock, rising edge
//   RST        in   1             asynchronous, active-high reset
//   IN_VALID   in   1             IN_DATA valid
//   IN_READY   out  1             controller can accept a word (state IDLE)
//   IN_DATA    in   4*NUM_DIGITS  packed BCD, digit NUM_DIGITS-1 in the MSBs
//   OUT_VALID  out  1             result valid, held until OUT_READY
//   OUT_READY  in   1             consumer accepts result
//   DIVISIBLE  out  1             word divisible by 11 and no BCD error
//   REMAINDER  out  4             word mod 11 (0..10), 4'hF on BCD error
//   BCD_ERR    out  1             some digit of the word was > 9
//   BUSY       out  1             digits are being walked (state RUN)
//   DBG_STATE  out  2             current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module bcd_div11_seq_ctrl #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [4*NUM_DIGITS-1:0]   IN_DATA,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic                      DIVISIBLE,
   output logic [3:0]                REMAINDER,
   output logic                      BCD_ERR,
   output logic                      BUSY,
   output logic [1:0]                DBG_STATE
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_shift;
   logic [3:0]      r_acc;
   logic            r_err;
   logic [CW-1:0]   r_cnt;
   logic            r_div;
   logic [3:0]      r_rem;
   logic            r_bcd_err;

   logic [3:0]      w_digit;
   logic [4:0]      w_t1;
   logic [4:0]      w_t2;
   logic [4:0]      w_t3;
   logic [3:0]      w_acc_next;
   logic            w_err_next;
   logic            w_accept;
   logic            w_last;

   // N*10 + d == d - N (mod 11); t = d + 11 - acc stays non-negative because
   // acc <= 10. A legal digit gives t in 1..20 so one subtract suffices; an
   // illegal digit can push t up to 26, and the second subtract keeps acc
   // inside 0..10 for the remaining digits.
   assign w_digit    = r_shift[W-1 -: 4];
   assign w_t1       = {1'b0, w_digit} + 5'd11 - {1'b0, r_acc};
   assign w_t2       = (w_t1 >= 5'd11) ? (w_t1 - 5'd11) : w_t1;
   assign w_t3       = (w_t2 >= 5'd11) ? (w_t2 - 5'd11) : w_t2;
   assign w_acc_next = w_t3[3:0];
   assign w_err_next = r_err | (w_digit > 4'd9);

   assign w_accept   = (r_state == IDLE) && IN_VALID;
   assign w_last     = (r_state == RUN) && (r_cnt == LAST_CNT);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_next    = r_state;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      BUSY      = 1'b0;
      case (r_state)
         IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) w_next = RUN;
         end
         RUN: begin
            BUSY = 1'b1;
            if (r_cnt == LAST_CNT) w_next = DONE;
         end
         DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Datapath: word load, digit walk, result capture on entry to DONE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_shift   <= '0;
         r_acc     <= 4'd0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
         r_div     <= 1'b0;
         r_rem     <= 4'd0;
         r_bcd_err <= 1'b0;
      end else if (w_accept) begin
         r_shift <= IN_DATA;
         r_acc   <= 4'd0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_shift <= r_shift << 4;
         r_acc   <= w_acc_next;
         r_err   <= w_err_next;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            // Result registers hold until the next word finishes.
            r_rem     <= w_err_next ? 4'hF : w_acc_next;
            r_div     <= !w_err_next && (w_acc_next == 4'd0);
            r_bcd_err <= w_err_next;
         end
      end
   end

   assign DIVISIBLE = r_div;
   assign REMAINDER = r_rem;
   assign BCD_ERR   = r_bcd_err;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_bcd_div11_seq_ctrl.sv
module tb_bcd_div11_seq_ctrl;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        DIVISIBLE;
  logic [3:0]  REMAINDER;
  logic        BCD_ERR;
  logic        BUSY;
  logic [1:0]  DBG_STATE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 0;
  logic [5:0] exp_q[$];   // {bcd_err, divisible, remainder}

  bcd_div11_seq_ctrl #(.NUM_DIGITS(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DIVISIBLE (DIVISIBLE),
    .REMAINDER (REMAINDER),
    .BCD_ERR   (BCD_ERR),
    .BUSY      (BUSY),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [5:0] ref_res(input logic [15:0] w);
    int v;
    bit err;
    int r;
    err = 0;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      if (w[4*i +: 4] > 4'd9) err = 1;
      v = v * 10 + int'(w[4*i +: 4]);
    end
    r = v % 11;
    if (err) ref_res = {1'b1, 1'b0, 4'hF};
    else     ref_res = {1'b0, (r == 0), 4'(r)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin
    if (sb_en && OUT_VALID && OUT_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got result %h with no expected entry", {BCD_ERR, DIVISIBLE, REMAINDER});
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({BCD_ERR, DIVISIBLE, REMAINDER} !== e) begin
          failures++;
          $display("FAIL sb_result: got %h expected %h", {BCD_ERR, DIVISIBLE, REMAINDER}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer a word and wait (bounded) for the accept edge; ends #1 after it.
  task automatic drive_word(input logic [15:0] w, output bit ok);
    int n;
    n = 0;
    IN_DATA = w;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 20) begin
      tick();
      n++;
    end
    ok = IN_READY;
    if (ok) tick();
    IN_VALID = 1'b0;
  endtask

  // Count edges until OUT_VALID (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA = 16'h0;
    OUT_READY = 1'b0;
    tick();
    tick();
    checks++;
    if ({IN_READY, OUT_VALID, DIVISIBLE, REMAINDER, BCD_ERR, BUSY, DBG_STATE} !== 11'b1_0_0_0000_0_0_00) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {IN_READY, OUT_VALID, DIVISIBLE, REMAINDER, BCD_ERR, BUSY, DBG_STATE}, 11'b1_0_0_0000_0_0_00);
    end
    RST = 1'b0;
    tick();
    checks++;
    if ({IN_READY, OUT_VALID, BUSY} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset_idle: got %b expected %b", {IN_READY, OUT_VALID, BUSY}, 3'b100);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    OUT_READY = 1'b1;
    drive_word(16'h1210, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_accept: got timeout expected accept");
    end
    checks++;
    if ({BUSY, IN_READY, OUT_VALID} !== 3'b100) begin
      failures++;
      $display("FAIL basic_run_flags: got %b expected %b", {BUSY, IN_READY, OUT_VALID}, 3'b100);
    end
    wait_result(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, 4);
    end
    checks++;
    if ({BCD_ERR, DIVISIBLE, REMAINDER} !== 6'b0_1_0000) begin
      failures++;
      $display("FAIL basic_result: got %b expected %b", {BCD_ERR, DIVISIBLE, REMAINDER}, 6'b0_1_0000);
    end
    tick();
    checks++;
    if ({OUT_VALID, IN_READY} !== 2'b01) begin
      failures++;
      $display("FAIL basic_release: got %b expected %b", {OUT_VALID, IN_READY}, 2'b01);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] words[5];
    logic [5:0]  exps[5];
    bit ok;
    int lat;
    words = '{16'h1234, 16'h9999, 16'h0000, 16'h12A4, 16'h999A};
    exps  = '{6'b0_0_0010, 6'b0_1_0000, 6'b0_1_0000, 6'b1_0_1111, 6'b1_0_1111};
    OUT_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_word(words[k], ok);
      wait_result(lat);
      checks++;
      if (!ok || lat !== 4) begin
        failures++;
        $display("FAIL pattern_latency[%0d]: got ok=%0d lat=%0d expected ok=1 lat=4", k, ok, lat);
      end
      checks++;
      if ({BCD_ERR, DIVISIBLE, REMAINDER} !== exps[k]) begin
        failures++;
        $display("FAIL pattern_result[%0d] %h: got %b expected %b", k, words[k],
                 {BCD_ERR, DIVISIBLE, REMAINDER}, exps[k]);
      end
      tick();
      // Result registers keep their values after release.
      checks++;
      if ({OUT_VALID, BCD_ERR, DIVISIBLE, REMAINDER} !== {1'b0, exps[k]}) begin
        failures++;
        $display("FAIL pattern_hold_idle[%0d]: got %b expected %b", k,
                 {OUT_VALID, BCD_ERR, DIVISIBLE, REMAINDER}, {1'b0, exps[k]});
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    OUT_READY = 1'b0;
    drive_word(16'h0121, ok);
    wait_result(lat);
    checks++;
    if (!ok || lat !== 4) begin
      failures++;
      $display("FAIL bp_latency: got ok=%0d lat=%0d expected ok=1 lat=4", ok, lat);
    end
    // New word offered while the result is stalled must be ignored.
    IN_DATA = 16'h1234;
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({OUT_VALID, IN_READY, BUSY, DIVISIBLE, REMAINDER, DBG_STATE} !== 10'b1_0_0_1_0000_10) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got %b expected %b", i,
                 {OUT_VALID, IN_READY, BUSY, DIVISIBLE, REMAINDER, DBG_STATE}, 10'b1_0_0_1_0000_10);
      end
    end
    OUT_READY = 1'b1;
    tick();
    checks++;
    if ({OUT_VALID, IN_READY, BUSY} !== 3'b010) begin
      failures++;
      $display("FAIL bp_release: got %b expected %b", {OUT_VALID, IN_READY, BUSY}, 3'b010);
    end
    tick();
    IN_VALID = 1'b0;
    checks++;
    if ({BUSY, IN_READY} !== 2'b10) begin
      failures++;
      $display("FAIL bp_next_accept: got %b expected %b", {BUSY, IN_READY}, 2'b10);
    end
    wait_result(lat);
    checks++;
    if ({BCD_ERR, DIVISIBLE, REMAINDER} !== 6'b0_0_0010 || lat !== 4) begin
      failures++;
      $display("FAIL bp_next_result: got %b lat=%0d expected %b lat=4",
               {BCD_ERR, DIVISIBLE, REMAINDER}, lat, 6'b0_0_0010);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    OUT_READY = 1'b1;
    drive_word(16'h1234, ok);
    tick();
    tick();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({IN_READY, OUT_VALID, DIVISIBLE, REMAINDER, BCD_ERR, BUSY, DBG_STATE} !== 11'b1_0_0_0000_0_0_00) begin
      failures++;
      $display("FAIL rst_mid_run: got %b expected %b",
               {IN_READY, OUT_VALID, DIVISIBLE, REMAINDER, BCD_ERR, BUSY, DBG_STATE}, 11'b1_0_0_0000_0_0_00);
    end
    tick();
    RST = 1'b0;
    tick();
    tick();
    checks++;
    if ({OUT_VALID, IN_READY} !== 2'b01) begin
      failures++;
      $display("FAIL rst_no_result: got %b expected %b", {OUT_VALID, IN_READY}, 2'b01);
    end
    drive_word(16'h0055, ok);
    wait_result(lat);
    checks++;
    if (!ok || lat !== 4 || {BCD_ERR, DIVISIBLE, REMAINDER} !== 6'b0_1_0000) begin
      failures++;
      $display("FAIL rst_next_word: got ok=%0d lat=%0d res=%b expected ok=1 lat=4 res=%b",
               ok, lat, {BCD_ERR, DIVISIBLE, REMAINDER}, 6'b0_1_0000);
    end
    tick();
  endtask

  // Streams words with IN_VALID and OUT_READY held high; results go through
  // the scoreboard, accept spacing is checked here.
  task automatic run_stream(input int n, input bit rnd, input string tag);
    logic [15:0] dir_words[8];
    logic [15:0] w;
    int last_acc;
    int to;
    dir_words = '{16'h1210, 16'h1234, 16'h9999, 16'h0000,
                  16'h0121, 16'h0055, 16'h12A4, 16'h0011};
    exp_q.delete();
    sb_en = 1'b1;
    last_acc = -1;
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = rnd ? to_bcd(int'($urandom_range(0, 9999))) : dir_words[k % 8];
      IN_DATA = w;
      to = 0;
      while (!IN_READY && to < 20) begin
        tick();
        to++;
      end
      checks++;
      if (!IN_READY) begin
        failures++;
        $display("FAIL %s_ready_timeout[%0d]: got IN_READY=0 expected 1", tag, k);
        break;
      end
      tick();
      exp_q.push_back(ref_res(w));
      if (last_acc >= 0) begin
        checks++;
        if (cyc - last_acc !== 6) begin
          failures++;
          $display("FAIL %s_spacing[%0d]: got %0d expected %0d", tag, k, cyc - last_acc, 6);
        end
      end
      last_acc = cyc;
    end
    IN_VALID = 1'b0;
    to = 0;
    while (exp_q.size() != 0 && to < 20) begin
      tick();
      to++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending expected 0", tag, exp_q.size());
    end
    sb_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b0, "b2b");
  endtask

  task automatic test_random_sweep();
    run_stream(40, 1'b1, "sweep");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
